// File: rtl/innings_scoreboard_if.sv
// rtl/innings_scoreboard_if.sv - delivery event channel for the innings scoreboard
interface innings_scoreboard_if;
    logic       ball_valid;
    logic       ball_ready;
    logic [2:0] ball_runs;
    logic       ball_extra;
    logic       ball_wicket;

    modport master (
        output ball_valid,
        output ball_runs,
        output ball_extra,
        output ball_wicket,
        input  ball_ready
    );

    modport slave (
        input  ball_valid,
        input  ball_runs,
        input  ball_extra,
        input  ball_wicket,
        output ball_ready
    );
endinterface

// File: rtl/innings_scoreboard.sv
// rtl/innings_scoreboard.sv - two-innings cricket scoreboard with delivery validation
module innings_scoreboard (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    innings_scoreboard_if.slave   ball,
    output logic [7:0]            team1_runs,
    output logic [7:0]            team2_runs,
    output logic [3:0]            team1_wickets,
    output logic [3:0]            team2_wickets,
    output logic [6:0]            team_1_ball,
    output logic [6:0]            team_2_ball,
    output logic [3:0]            wickets,
    output logic [6:0]            balls,
    output logic                  batting_team,
    output logic                  bad_ball
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INN1  = 3'd1,
        BREAK = 3'd2,
        INN2  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] MAX_WKTS  = 4'd10;
    localparam logic [6:0] MAX_BALLS = 7'd120;

    state_t     state;
    state_t     state_nxt;

    logic       accept;
    logic       reject;
    logic       legal;
    logic [7:0] bat_runs;
    logic [8:0] run_sum;
    logic [7:0] runs_nxt;
    logic [3:0] wkts_nxt;
    logic [6:0] balls_nxt;

    // Deliveries are only taken while an innings is live; team 2 bats from INN2 onward.
    assign ball.ball_ready = (state == INN1) || (state == INN2);
    assign batting_team    = (state == INN2) || (state == DONE);

    assign bat_runs = batting_team ? team2_runs    : team1_runs;
    assign wickets  = batting_team ? team2_wickets : team1_wickets;
    assign balls    = batting_team ? team_2_ball   : team_1_ball;

    // Validate the delivery and compute the batting side's counters after it lands.
    always_comb begin
        accept    = ball.ball_valid && ball.ball_ready;
        reject    = accept && ((ball.ball_runs == 3'd7) ||
                               (ball.ball_extra && (ball.ball_runs > 3'd4)));
        legal     = accept && !reject;
        run_sum   = {1'b0, bat_runs} + {6'd0, ball.ball_runs} + {8'd0, ball.ball_extra};
        runs_nxt  = bat_runs;
        wkts_nxt  = wickets;
        balls_nxt = balls;
        if (legal) begin
            runs_nxt = run_sum[8] ? 8'hFF : run_sum[7:0];
            if (ball.ball_wicket && (wickets < MAX_WKTS))
                wkts_nxt = wickets + 4'd1;
            if (!ball.ball_extra && (balls < MAX_BALLS))
                balls_nxt = balls + 7'd1;
        end
    end

    // Match state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: an innings closes on the edge its tenth wicket or 120th ball lands.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INN1;
            INN1:    if ((wkts_nxt == MAX_WKTS) || (balls_nxt == MAX_BALLS)) state_nxt = BREAK;
            BREAK:   state_nxt = INN2;
            INN2:    if ((wkts_nxt == MAX_WKTS) || (balls_nxt == MAX_BALLS)) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Commit accepted deliveries to the batting side's counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            team1_runs    <= 8'd0;
            team2_runs    <= 8'd0;
            team1_wickets <= 4'd0;
            team2_wickets <= 4'd0;
            team_1_ball   <= 7'd0;
            team_2_ball   <= 7'd0;
        end else if (legal) begin
            if (batting_team) begin
                team2_runs    <= runs_nxt;
                team2_wickets <= wkts_nxt;
                team_2_ball   <= balls_nxt;
            end else begin
                team1_runs    <= runs_nxt;
                team1_wickets <= wkts_nxt;
                team_1_ball   <= balls_nxt;
            end
        end
    end

    // Flag a malformed delivery for one cycle after it is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bad_ball <= 1'b0;
        else
            bad_ball <= reject;
    end

endmodule

// File: tb/tb_innings_scoreboard.sv
// tb/tb_innings_scoreboard.sv - directed self-checking bench for innings_scoreboard
module tb_innings_scoreboard;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] team1_runs;
    logic [7:0] team2_runs;
    logic [3:0] team1_wickets;
    logic [3:0] team2_wickets;
    logic [6:0] team_1_ball;
    logic [6:0] team_2_ball;
    logic [3:0] wickets;
    logic [6:0] balls;
    logic       batting_team;
    logic       bad_ball;

    int n_compared;
    int n_mismatched;

    innings_scoreboard_if bif ();

    innings_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .ball          (bif.slave),
        .team1_runs    (team1_runs),
        .team2_runs    (team2_runs),
        .team1_wickets (team1_wickets),
        .team2_wickets (team2_wickets),
        .team_1_ball   (team_1_ball),
        .team_2_ball   (team_2_ball),
        .wickets       (wickets),
        .balls         (balls),
        .batting_team  (batting_team),
        .bad_ball      (bad_ball)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic deliver(input logic [2:0] r, input logic e, input logic w);
        bif.ball_valid  = 1'b1;
        bif.ball_runs   = r;
        bif.ball_extra  = e;
        bif.ball_wicket = w;
        @(posedge clk);
        #1;
        bif.ball_valid  = 1'b0;
        bif.ball_runs   = 3'd0;
        bif.ball_extra  = 1'b0;
        bif.ball_wicket = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        rst             = 1'b0;
        start           = 1'b0;
        bif.ball_valid  = 1'b0;
        bif.ball_runs   = 3'd0;
        bif.ball_extra  = 1'b0;
        bif.ball_wicket = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_t1_runs", team1_runs, 0);
        check("rst_ready", bif.ball_ready, 0);
        check("rst_batting", batting_team, 0);
        check("rst_bad", bad_ball, 0);
        check("rst_balls", balls, 0);
        @(negedge clk);
        rst = 1'b1;

        // delivery in IDLE is ignored
        deliver(3'd3, 1'b0, 1'b0);
        check("idle_runs", team1_runs, 0);
        check("idle_bad", bad_ball, 0);
        check("idle_balls", team_1_ball, 0);

        start_pulse();
        check("inn1_ready", bif.ball_ready, 1);
        check("inn1_batting", batting_team, 0);

        // extras and a legal ball
        deliver(3'd4, 1'b1, 1'b0);
        check("wide4_runs", team1_runs, 5);
        check("wide4_balls", team_1_ball, 0);
        deliver(3'd0, 1'b1, 1'b1);
        check("nb_wkt_wkts", team1_wickets, 1);
        check("nb_wkt_balls", team_1_ball, 0);
        check("nb_wkt_runs", team1_runs, 6);
        check("nb_wkt_sel_wkts", wickets, 1);
        deliver(3'd2, 1'b0, 1'b0);
        check("legal2_runs", team1_runs, 8);
        check("legal2_balls", balls, 1);

        // rejected deliveries
        deliver(3'd7, 1'b0, 1'b1);
        check("r7_bad", bad_ball, 1);
        check("r7_runs", team1_runs, 8);
        check("r7_balls", team_1_ball, 1);
        check("r7_wkts", team1_wickets, 1);
        @(posedge clk);
        #1;
        check("r7_bad_clear", bad_ball, 0);
        deliver(3'd5, 1'b1, 1'b0);
        check("x5_bad", bad_ball, 1);
        check("x5_runs", team1_runs, 8);
        check("x5_wkts", team1_wickets, 1);

        // full 20 overs of singles
        do_reset();
        check("rerst_runs", team1_runs, 0);
        check("rerst_wkts", team1_wickets, 0);
        start_pulse();
        for (int i = 0; i < 120; i++) deliver(3'd1, 1'b0, 1'b0);
        check("ov_runs", team1_runs, 120);
        check("ov_balls", team_1_ball, 120);
        check("break_ready", bif.ball_ready, 0);
        check("break_batting", batting_team, 0);
        @(posedge clk);
        #1;
        check("inn2_batting", batting_team, 1);
        check("inn2_ready", bif.ball_ready, 1);
        check("inn2_balls", balls, 0);
        deliver(3'd3, 1'b0, 1'b1);
        check("inn2_t2_runs", team2_runs, 3);
        check("inn2_wkts", wickets, 1);
        check("inn2_balls1", balls, 1);
        check("inn2_t1_hold", team1_runs, 120);

        // asynchronous reset between edges
        #3;
        rst = 1'b0;
        #1;
        check("async_t1_runs", team1_runs, 0);
        check("async_t2_runs", team2_runs, 0);
        check("async_t1_ball", team_1_ball, 0);
        check("async_batting", batting_team, 0);
        check("async_ready", bif.ball_ready, 0);
        check("async_wkts", team2_wickets, 0);
        @(negedge clk);
        rst = 1'b1;
        start_pulse();
        check("fresh_ready", bif.ball_ready, 1);
        check("fresh_batting", batting_team, 0);

        // all out after 30 dot balls
        for (int i = 0; i < 30; i++) deliver(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) deliver(3'd0, 1'b0, 1'b1);
        check("w9_ready", bif.ball_ready, 1);
        check("w9_wkts", team1_wickets, 9);
        deliver(3'd0, 1'b0, 1'b1);
        check("allout_wkts", team1_wickets, 10);
        check("allout_balls", team_1_ball, 40);
        check("allout_ready", bif.ball_ready, 0);
        @(posedge clk);
        #1;
        check("allout_inn2", batting_team, 1);

        // second innings all out -> DONE, which holds
        for (int i = 0; i < 10; i++) deliver(3'd1, 1'b0, 1'b1);
        check("done_t2_wkts", team2_wickets, 10);
        check("done_t2_runs", team2_runs, 10);
        check("done_t2_ball", team_2_ball, 10);
        check("done_ready", bif.ball_ready, 0);
        start_pulse();
        deliver(3'd2, 1'b0, 1'b0);
        check("done_hold_runs", team2_runs, 10);
        check("done_hold_ready", bif.ball_ready, 0);
        check("done_hold_bat", batting_team, 1);
        check("done_no_bad", bad_ball, 0);

        // run saturation
        do_reset();
        start_pulse();
        for (int i = 0; i < 60; i++) deliver(3'd6, 1'b0, 1'b0);
        check("sat_runs", team1_runs, 255);
        check("sat_balls", team_1_ball, 60);
        check("sat_ready", bif.ball_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/innings_scoreboard.md
INNINGS_SCOREBOARD -- requirements
Module: innings_scoreboard

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: start  input  1  one-cycle pulse; begins a match from IDLE.
REQ-004 SHALL have ports: ball_valid  input  1  delivery event present.
REQ-005 SHALL have ports: ball_ready  output  1  block accepts a delivery this cycle.
REQ-006 SHALL have ports: ball_runs  input  3  runs off the delivery (0..6).
REQ-007 SHALL have ports: ball_extra  input  1  wide/no-ball; not a legal ball.
REQ-008 SHALL have ports: ball_wicket  input  1  wicket fell on this delivery.
REQ-009 SHALL have ports: team1_runs, team2_runs  output  8 each  innings totals.
REQ-010 SHALL have ports: team1_wickets, team2_wickets  output  4 each.
REQ-011 SHALL have ports: team_1_ball, team_2_ball  output  7 each  legal balls bowled.
REQ-012 SHALL have ports: wickets  output  4  and balls  output  7  (batting side's counters).
REQ-013 SHALL have ports: batting_team  output  1  (0 = team1, 1 = team2).
REQ-014 SHALL have ports: bad_ball  output  1  one-cycle pulse on a rejected delivery.

Function
REQ-015 SHALL implement FSM states IDLE, INN1, BREAK, INN2, DONE.
REQ-016 SHALL move IDLE->INN1 on start; start SHALL be ignored in all other states.
REQ-017 SHALL drive ball_ready=1 only in INN1 and INN2; an event is accepted when ball_valid && ball_ready at a rising edge.
REQ-018 SHALL update all counters on the edge that accepts the event (1-cycle latency to outputs).
REQ-019 SHALL add ball_runs to the batting team's runs for a legal ball, and ball_runs+1 for an extra.
REQ-020 SHALL increment the batting team's ball count by 1 only for a legal ball (ball_extra=0).
REQ-021 SHALL increment the batting team's wickets by 1 when ball_wicket=1, whether or not the delivery is an extra.
REQ-022 SHALL saturate runs at 255; wickets SHALL never exceed 10, balls SHALL never exceed 120.
REQ-023 SHALL reject an accepted event with ball_runs=7, or with ball_extra=1 and ball_runs>4: no counter change, bad_ball=1 on the next cycle.
REQ-024 SHALL transition INN1->BREAK on the edge where team1_wickets becomes 10 or team_1_ball becomes 120; both conditions on the same edge give the same transition.
REQ-025 SHALL remain in BREAK for exactly one cycle, then enter INN2.
REQ-026 SHALL transition INN2->DONE on the edge where team2_wickets becomes 10 or team_2_ball becomes 120; there is no early finish on reaching the target.
REQ-027 SHALL hold DONE and all counters until reset; a start in DONE SHALL be ignored.
REQ-028 SHALL drive batting_team=0 in IDLE, INN1 and BREAK, and 1 in INN2 and DONE.
REQ-029 SHALL drive wickets/balls from team1 counters when batting_team=0, else from team2 counters.
REQ-030 SHALL ignore ball_valid in IDLE, BREAK and DONE, with no bad_ball pulse.

Reset
REQ-031 SHALL, on rst=0, immediately and asynchronously force state=IDLE.
REQ-032 SHALL, on rst=0, force all run, wicket and ball counters to 0.
REQ-033 SHALL, on rst=0, force bad_ball=0, ball_ready=0 and batting_team=0.
REQ-034 SHALL resume from IDLE on the first rising edge after rst returns to 1.
REQ-035 SHALL treat reset asserted mid-innings as abandoning the match: no counter values are retained.

Verification
REQ-036 SHALL cover: start, then 120 legal deliveries of 1 run each -> team1_runs=120, team_1_ball=120, BREAK for 1 cycle, then batting_team=1, balls=0.
REQ-037 SHALL cover: in INN1, 10 deliveries with ball_wicket=1 after 30 balls -> state goes to BREAK on the 10th, with team1_wickets=10 and team_1_ball=40.
REQ-038 SHALL cover: a wide with ball_runs=4 -> runs +5, ball count unchanged; a no-ball wicket -> wickets +1, balls unchanged.
REQ-039 SHALL cover: 60 sixes (360 runs) -> team1_runs saturates at 255.
REQ-040 SHALL cover: ball_runs=7, and an extra with ball_runs=5 -> bad_ball pulses once for each, with counters unchanged.
REQ-041 SHALL cover: rst=0 asserted mid-INN2 between clock edges -> outputs reach 0 and IDLE before the next edge; a later start begins a fresh INN1.
